// File: rtl/rop3_pkg.sv
// Shared ROP3 codes, FSM encoding and FIFO count-width helper for the ROP3 stream engine.
package rop3_pkg;

  localparam logic [7:0] ROP_BLACKNESS = 8'h00;
  localparam logic [7:0] ROP_SRCAND    = 8'h88;
  localparam logic [7:0] ROP_SRCINVERT = 8'h66;
  localparam logic [7:0] ROP_SRCCOPY   = 8'hCC;
  localparam logic [7:0] ROP_PATCOPY   = 8'hF0;
  localparam logic [7:0] ROP_WHITENESS = 8'hFF;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_OPEN = 1'b1;

  // Count must represent 0..DEPTH inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/rop3_stream_engine_if.sv
// Beat stream bundle: P/S/D input beats in, ROP results out, each with valid/ready and packet framing.
interface rop3_stream_engine_if #(
  parameter int N     = 4,
  parameter int LANES = 2
);
  logic               in_valid;
  logic               in_ready;
  logic [LANES*N-1:0] in_p;
  logic [LANES*N-1:0] in_s;
  logic [LANES*N-1:0] in_d;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [LANES*N-1:0] out_result;
  logic               out_last;

  modport master (
    output in_valid, in_p, in_s, in_d, in_last, out_ready,
    input  in_ready, out_valid, out_result, out_last
  );

  modport slave (
    input  in_valid, in_p, in_s, in_d, in_last, out_ready,
    output in_ready, out_valid, out_result, out_last
  );
endinterface

// File: rtl/rop3_out_fifo.sv
// Synchronous FIFO with occupancy count; push and pop may coincide, pop is ignored when empty.
module rop3_out_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_dat_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       pop_dat_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && (count_q != (AW+1)'(DEPTH));

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign pop_dat_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

endmodule

// File: rtl/rop3_stream_engine.sv
// Multi-lane ROP3 engine: capture stage, ROP stage into output FIFO (2-edge latency when empty).
// in_ready looks only at registered occupancy, so out_ready never reaches it combinationally.
module rop3_stream_engine
  import rop3_pkg::*;
#(
  parameter int         N        = 4,
  parameter int         LANES    = 2,
  parameter int         DEPTH    = 4,
  parameter logic [7:0] MODE_RST = ROP_SRCCOPY
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                mode_we_i,
  input  logic [7:0]          mode_in_i,
  output logic [7:0]          active_mode_o,
  output logic                busy_o,
  rop3_stream_engine_if.slave bus
);
  localparam int W  = LANES * N;
  localparam int CW = cnt_w(DEPTH);

  logic [0:0]  state_q, state_d;
  logic        pending_q, pending_d;
  logic [7:0]  pending_mode_q, pending_mode_d;
  logic [7:0]  active_mode_q, active_mode_d;

  logic        s1_valid_q;
  logic [W-1:0] s1_p_q, s1_s_q, s1_d_q;
  logic        s1_last_q;
  logic [7:0]  s1_mode_q;

  logic [W-1:0]  rop_res;
  logic [W:0]    fifo_dat;
  logic [CW-1:0] fifo_cnt;
  logic [CW:0]   occ;
  logic          accept;
  logic          out_vld;

  assign occ          = {1'b0, fifo_cnt} + {{CW{1'b0}}, s1_valid_q};
  assign bus.in_ready = occ < (CW+1)'(DEPTH);
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    state_d        = state_q;
    pending_d      = pending_q;
    pending_mode_d = pending_mode_q;
    active_mode_d  = active_mode_q;
    if (state_q == ST_IDLE) begin
      if (mode_we_i) active_mode_d = mode_in_i;
      if (accept && !bus.in_last) state_d = ST_OPEN;
    end else begin
      // Mid-packet writes are parked so every beat of a packet sees one mode.
      if (mode_we_i) begin
        pending_mode_d = mode_in_i;
        pending_d      = 1'b1;
      end
      if (accept && bus.in_last) begin
        state_d   = ST_IDLE;
        pending_d = 1'b0;
        if (mode_we_i)      active_mode_d = mode_in_i;
        else if (pending_q) active_mode_d = pending_mode_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      pending_q      <= 1'b0;
      pending_mode_q <= MODE_RST;
      active_mode_q  <= MODE_RST;
      s1_valid_q     <= 1'b0;
      s1_p_q         <= '0;
      s1_s_q         <= '0;
      s1_d_q         <= '0;
      s1_last_q      <= 1'b0;
      s1_mode_q      <= MODE_RST;
    end else begin
      state_q        <= state_d;
      pending_q      <= pending_d;
      pending_mode_q <= pending_mode_d;
      active_mode_q  <= active_mode_d;
      s1_valid_q     <= accept;
      if (accept) begin
        s1_p_q    <= bus.in_p;
        s1_s_q    <= bus.in_s;
        s1_d_q    <= bus.in_d;
        s1_last_q <= bus.in_last;
        s1_mode_q <= active_mode_q;
      end
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    for (genvar i = 0; i < N; i++) begin : g_bit
      assign rop_res[k*N+i] = s1_mode_q[{s1_p_q[k*N+i], s1_s_q[k*N+i], s1_d_q[k*N+i]}];
    end
  end

  // Room for the stage-1 beat is reserved by in_ready, so the push never stalls.
  rop3_out_fifo #(
    .WIDTH (W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (s1_valid_q),
    .push_dat_i ({s1_last_q, rop_res}),
    .pop_i      (bus.out_ready),
    .pop_dat_o  (fifo_dat),
    .count_o    (fifo_cnt)
  );

  assign out_vld                       = fifo_cnt != '0;
  assign bus.out_valid                 = out_vld;
  assign {bus.out_last, bus.out_result} = out_vld ? fifo_dat : '0;

  assign active_mode_o = active_mode_q;
  assign busy_o        = (state_q == ST_OPEN) || s1_valid_q || out_vld;

endmodule

// File: tb/tb_rop3_stream_engine.sv
// Directed bench for rop3_stream_engine: function table, mode sweep, backpressure, mode switching, reset.
module tb_rop3_stream_engine;
  import rop3_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode_we;
  logic [7:0] mode_in;
  logic [7:0] active_mode;
  logic       busy;
  int         passed = 0;
  int         total  = 0;

  rop3_stream_engine_if #(.N(4), .LANES(2)) bus ();

  rop3_stream_engine #(
    .N(4), .LANES(2), .DEPTH(4), .MODE_RST(8'hCC)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .mode_we_i     (mode_we),
    .mode_in_i     (mode_in),
    .active_mode_o (active_mode),
    .busy_o        (busy),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Sum-of-minterms form of the ROP3 truth table.
  function automatic logic [7:0] rop_model(input logic [7:0] m, input logic [7:0] p,
                                           input logic [7:0] s, input logic [7:0] d);
    logic [7:0] r;
    r = 8'h00;
    if (m[7]) r = r | ( p &  s &  d);
    if (m[6]) r = r | ( p &  s & ~d);
    if (m[5]) r = r | ( p & ~s &  d);
    if (m[4]) r = r | ( p & ~s & ~d);
    if (m[3]) r = r | (~p &  s &  d);
    if (m[2]) r = r | (~p &  s & ~d);
    if (m[1]) r = r | (~p & ~s &  d);
    if (m[0]) r = r | (~p & ~s & ~d);
    return r;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_mode(input logic [7:0] m);
    mode_we = 1'b1;
    mode_in = m;
    step();
    mode_we = 1'b0;
  endtask

  task automatic drive_beat(input logic [7:0] p, input logic [7:0] s,
                            input logic [7:0] d, input logic last);
    bus.in_valid = 1'b1;
    bus.in_p     = p;
    bus.in_s     = s;
    bus.in_d     = d;
    bus.in_last  = last;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL reset out_valid: got %b want 0", bus.out_valid); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset busy: got %b want 0", busy); else passed++;
    total++; if (active_mode !== 8'hCC) $display("FAIL reset active_mode: got %h want cc", active_mode); else passed++;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL reset in_ready: got %b want 1", bus.in_ready); else passed++;
    total++; if (bus.out_result !== 8'h00) $display("FAIL reset out_result: got %h want 00", bus.out_result); else passed++;
    total++; if (bus.out_last !== 1'b0) $display("FAIL reset out_last: got %b want 0", bus.out_last); else passed++;
  endtask

  task automatic test_function;
    logic [7:0] modes [7];
    logic [7:0] exps  [7];
    modes = '{ROP_PATCOPY, ROP_SRCCOPY, 8'hAA, ROP_SRCAND, ROP_SRCINVERT, ROP_BLACKNESS, ROP_WHITENESS};
    exps  = '{8'h5A, 8'h33, 8'h0F, 8'h03, 8'h3C, 8'h00, 8'hFF};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      set_mode(modes[i]);
      total++; if (active_mode !== modes[i]) $display("FAIL func[%0d] active_mode: got %h want %h", i, active_mode, modes[i]); else passed++;
      drive_beat(8'h5A, 8'h33, 8'h0F, 1'b1);
      step();
      bus.in_valid = 1'b0;
      total++; if (bus.out_valid !== 1'b0) $display("FAIL func[%0d] early out_valid: got %b want 0", i, bus.out_valid); else passed++;
      step();
      total++; if (bus.out_valid !== 1'b1) $display("FAIL func[%0d] out_valid: got %b want 1", i, bus.out_valid); else passed++;
      total++; if (bus.out_result !== exps[i]) $display("FAIL func[%0d] out_result: got %h want %h", i, bus.out_result, exps[i]); else passed++;
      total++; if (bus.out_last !== 1'b1) $display("FAIL func[%0d] out_last: got %b want 1", i, bus.out_last); else passed++;
      step();
    end
  endtask

  task automatic test_sweep;
    logic [7:0] q [$];
    logic [7:0] e;
    int sent, got, cyc;
    bus.out_ready = 1'b1;
    for (int m = 0; m < 256; m++) begin
      set_mode(8'(m));
      sent = 0; got = 0; cyc = 0;
      drive_beat(8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
      while (got < 64 && cyc < 300) begin
        if (bus.out_valid) begin
          total++;
          if (q.size() == 0) begin
            $display("FAIL sweep mode %h extra beat: got %h want none", 8'(m), bus.out_result);
          end else begin
            e = q.pop_front();
            if (bus.out_result !== e) $display("FAIL sweep mode %h beat %0d: got %h want %h", 8'(m), got, bus.out_result, e);
            else passed++;
          end
          got++;
        end
        if (bus.in_valid && bus.in_ready) begin
          q.push_back(rop_model(8'(m), bus.in_p, bus.in_s, bus.in_d));
          sent++;
        end
        step();
        cyc++;
        if (sent < 64) drive_beat(8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
        else bus.in_valid = 1'b0;
      end
      total++;
      if (got != 64 || q.size() != 0) $display("FAIL sweep mode %h count: got %0d want 64", 8'(m), got);
      else passed++;
      q.delete();
    end
  endtask

  task automatic test_backpressure;
    int sent, got, cyc;
    logic acc;
    set_mode(ROP_SRCCOPY);
    bus.out_ready = 1'b0;
    sent = 0;
    for (int c = 0; c < 8; c++) begin
      drive_beat(8'h00, 8'(16 + sent), 8'h00, 1'b1);
      acc = bus.in_ready;
      step();
      if (acc) sent++;
    end
    total++; if (sent != 4) $display("FAIL bp accepted: got %0d want 4", sent); else passed++;
    total++; if (bus.in_ready !== 1'b0) $display("FAIL bp in_ready: got %b want 0", bus.in_ready); else passed++;
    total++; if (bus.out_result !== 8'h10) $display("FAIL bp held result: got %h want 10", bus.out_result); else passed++;
    bus.out_ready = 1'b1;
    got = 0; cyc = 0;
    while (got < 8 && cyc < 60) begin
      if (bus.out_valid) begin
        total++;
        if (bus.out_result !== 8'(16 + got)) $display("FAIL bp order[%0d]: got %h want %h", got, bus.out_result, 8'(16 + got));
        else passed++;
        got++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      step();
      cyc++;
      if (sent < 8) drive_beat(8'h00, 8'(16 + sent), 8'h00, 1'b1);
      else bus.in_valid = 1'b0;
    end
    total++; if (got != 8) $display("FAIL bp drained: got %0d want 8", got); else passed++;
    step();
    total++; if (bus.out_valid !== 1'b0) $display("FAIL bp no duplicate: got %b want 0", bus.out_valid); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL bp busy idle: got %b want 0", busy); else passed++;
  endtask

  task automatic test_mode_switch;
    set_mode(ROP_SRCCOPY);
    bus.out_ready = 1'b1;
    drive_beat(8'h5A, 8'h33, 8'h0F, 1'b0);
    step();
    total++; if (active_mode !== 8'hCC) $display("FAIL msw beat1 active: got %h want cc", active_mode); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL msw busy open: got %b want 1", busy); else passed++;
    mode_we = 1'b1;
    mode_in = ROP_PATCOPY;
    step();
    mode_we = 1'b0;
    total++; if (bus.out_result !== 8'h33 || bus.out_last !== 1'b0) $display("FAIL msw beat1 out: got %h/%b want 33/0", bus.out_result, bus.out_last); else passed++;
    total++; if (active_mode !== 8'hCC) $display("FAIL msw pending active: got %h want cc", active_mode); else passed++;
    bus.in_last = 1'b1;
    step();
    bus.in_valid = 1'b0;
    total++; if (bus.out_result !== 8'h33 || bus.out_last !== 1'b0) $display("FAIL msw beat2 out: got %h/%b want 33/0", bus.out_result, bus.out_last); else passed++;
    total++; if (active_mode !== 8'hF0) $display("FAIL msw active at last: got %h want f0", active_mode); else passed++;
    step();
    total++; if (bus.out_result !== 8'h33 || bus.out_last !== 1'b1) $display("FAIL msw beat3 out: got %h/%b want 33/1", bus.out_result, bus.out_last); else passed++;
    drive_beat(8'h5A, 8'h33, 8'h0F, 1'b1);
    step();
    bus.in_valid = 1'b0;
    step();
    total++; if (bus.out_valid !== 1'b1 || bus.out_result !== 8'h5A) $display("FAIL msw next packet: got %b/%h want 1/5a", bus.out_valid, bus.out_result); else passed++;
    step();
    total++; if (busy !== 1'b0) $display("FAIL msw busy end: got %b want 0", busy); else passed++;
  endtask

  task automatic test_simultaneous;
    set_mode(ROP_SRCCOPY);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_beat(8'h00, 8'(8'h20 + i), 8'h00, 1'b1);
      step();
    end
    bus.in_valid = 1'b0;
    total++; if (bus.in_ready !== 1'b0) $display("FAIL sim full in_ready: got %b want 0", bus.in_ready); else passed++;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    total++; if (bus.out_result !== 8'h21) $display("FAIL sim head after pop: got %h want 21", bus.out_result); else passed++;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL sim in_ready at 3: got %b want 1", bus.in_ready); else passed++;
    drive_beat(8'h00, 8'h24, 8'h00, 1'b1);
    step();
    bus.in_valid = 1'b0;
    total++; if (bus.in_ready !== 1'b0) $display("FAIL sim in_ready 3+1: got %b want 0", bus.in_ready); else passed++;
    step();
    total++; if (bus.in_ready !== 1'b0) $display("FAIL sim in_ready 4: got %b want 0", bus.in_ready); else passed++;
    bus.out_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_result !== 8'(8'h20 + i))
        $display("FAIL sim drain[%0d]: got %b/%h want 1/%h", i, bus.out_valid, bus.out_result, 8'(8'h20 + i));
      else passed++;
      step();
    end
    total++; if (bus.out_valid !== 1'b0) $display("FAIL sim empty: got %b want 0", bus.out_valid); else passed++;
  endtask

  task automatic test_reset_mid;
    set_mode(ROP_PATCOPY);
    bus.out_ready = 1'b0;
    drive_beat(8'h5A, 8'h33, 8'h0F, 1'b0);
    step();
    step();
    mode_we = 1'b1;
    mode_in = ROP_BLACKNESS;
    step();
    mode_we = 1'b0;
    bus.in_valid = 1'b0;
    total++; if (busy !== 1'b1 || bus.out_valid !== 1'b1) $display("FAIL rmid pre: got %b/%b want 1/1", busy, bus.out_valid); else passed++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL rmid out_valid: got %b want 0", bus.out_valid); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rmid busy: got %b want 0", busy); else passed++;
    total++; if (active_mode !== 8'hCC) $display("FAIL rmid active_mode: got %h want cc", active_mode); else passed++;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL rmid in_ready: got %b want 1", bus.in_ready); else passed++;
    bus.out_ready = 1'b1;
    drive_beat(8'h5A, 8'h33, 8'h0F, 1'b1);
    step();
    bus.in_valid = 1'b0;
    total++; if (active_mode !== 8'hCC) $display("FAIL rmid stale pending: got %h want cc", active_mode); else passed++;
    step();
    total++; if (bus.out_valid !== 1'b1 || bus.out_result !== 8'h33 || bus.out_last !== 1'b1)
      $display("FAIL rmid result: got %b/%h/%b want 1/33/1", bus.out_valid, bus.out_result, bus.out_last); else passed++;
    step();
    total++; if (bus.out_valid !== 1'b0) $display("FAIL rmid no leftovers: got %b want 0", bus.out_valid); else passed++;
  endtask

  initial begin
    rst           = 1'b1;
    mode_we       = 1'b0;
    mode_in       = 8'h00;
    bus.in_valid  = 1'b0;
    bus.in_p      = '0;
    bus.in_s      = '0;
    bus.in_d      = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_function();
    test_sweep();
    test_backpressure();
    test_mode_switch();
    test_simultaneous();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
